// File: rtl/subinvmult_stream_ctrl.sv
// subinvmult_stream_ctrl
//   Streaming wrapper around an external fixed-latency modular
//   sub-inverse-multiply core. Operand pairs are queued in a small input
//   FIFO, range-checked on acceptance, launched into the core only when the
//   output FIFO is guaranteed to have room for the result, and the core
//   results are collected in order into an output FIFO.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand pair handshake, in_a/in_b operands
//   core_a/core_b         registered operands driving the core
//   core_vld              high in cycles where core_a/core_b carry a launch
//   core_result           core output, valid PIPE_LAT cycles after core_vld
//   out_valid/out_ready   result handshake, out_data result, out_err flag
module subinvmult_stream_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int MODULUS    = 177147,
  parameter int PIPE_LAT   = 8,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_b,
  output logic                  core_vld,
  input  logic [DATA_WIDTH-1:0] core_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  localparam int IAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int IEW = 2 * DATA_WIDTH + 1;
  localparam int OEW = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH:0] MOD_W    = (DATA_WIDTH + 1)'(MODULUS);
  localparam logic [OCW:0]        OUT_CAP  = (OCW + 1)'(OUT_DEPTH);

  logic                  readyEn_q;
  logic [IEW-1:0]        inMem_q [IN_DEPTH];
  logic [IAW-1:0]        inWr_q, inWr_d, inRd_q, inRd_d;
  logic [ICW-1:0]        inCnt_q, inCnt_d;
  logic                  inFull, inEmpty, inPush, launch, creditOk, entryErr;
  logic [IEW-1:0]        inEntry, inHead;

  logic [DATA_WIDTH-1:0] coreA_q, coreA_d, coreB_q, coreB_d;
  logic                  coreVld_q, coreErr_q, coreErr_d;
  logic [PIPE_LAT-1:0]   srVld_q, srErr_q;
  logic                  capture;

  logic [OEW-1:0]        outMem_q [OUT_DEPTH];
  logic [OEW-1:0]        outHead;
  logic [OAW-1:0]        outWr_q, outWr_d, outRd_q, outRd_d;
  logic [OCW-1:0]        outCnt_q, outCnt_d, inflight_q, inflight_d;
  logic [OCW:0]          occupied;
  logic                  outPop;

  function automatic logic [IAW-1:0] nextIn(input logic [IAW-1:0] p);
    return (p == IAW'(IN_DEPTH - 1)) ? '0 : p + IAW'(1);
  endfunction

  function automatic logic [OAW-1:0] nextOut(input logic [OAW-1:0] p);
    return (p == OAW'(OUT_DEPTH - 1)) ? '0 : p + OAW'(1);
  endfunction

  // Out-of-range pairs are still queued so ordering is preserved, but their
  // operands are zeroed so the core never sees an illegal residue.
  assign entryErr = ({1'b0, in_a} >= MOD_W) || ({1'b0, in_b} >= MOD_W);
  assign inEntry  = entryErr ? {1'b1, {(2 * DATA_WIDTH){1'b0}}} : {1'b0, in_a, in_b};
  assign inHead   = inMem_q[inRd_q];

  // readyEn_q keeps in_ready low during reset and lets it rise one edge later.
  assign inFull   = (inCnt_q == ICW'(IN_DEPTH));
  assign inEmpty  = (inCnt_q == '0);
  assign in_ready = readyEn_q && !inFull;
  assign inPush   = in_valid && in_ready;

  // A launch reserves an output FIFO slot, so results never overflow it.
  assign occupied = {1'b0, inflight_q} + {1'b0, outCnt_q};
  assign creditOk = (occupied < OUT_CAP);
  assign launch   = !inEmpty && creditOk;

  assign capture   = srVld_q[PIPE_LAT-1];
  assign out_valid = (outCnt_q != '0);
  assign outPop    = out_valid && out_ready;
  assign outHead   = outMem_q[outRd_q];
  assign out_data  = out_valid ? outHead[DATA_WIDTH-1:0] : '0;
  assign out_err   = out_valid ? outHead[DATA_WIDTH] : 1'b0;

  assign core_a   = coreA_q;
  assign core_b   = coreB_q;
  assign core_vld = coreVld_q;

  // Next-state computation for pointers, occupancy counters and core operands.
  always_comb begin
    inWr_d     = inPush ? nextIn(inWr_q) : inWr_q;
    inRd_d     = launch ? nextIn(inRd_q) : inRd_q;
    outWr_d    = capture ? nextOut(outWr_q) : outWr_q;
    outRd_d    = outPop ? nextOut(outRd_q) : outRd_q;
    coreA_d    = launch ? inHead[2*DATA_WIDTH-1:DATA_WIDTH] : coreA_q;
    coreB_d    = launch ? inHead[DATA_WIDTH-1:0] : coreB_q;
    coreErr_d  = launch ? inHead[2*DATA_WIDTH] : coreErr_q;
    inCnt_d    = inCnt_q;
    outCnt_d   = outCnt_q;
    inflight_d = inflight_q;
    case ({inPush, launch})
      2'b10:   inCnt_d = inCnt_q + ICW'(1);
      2'b01:   inCnt_d = inCnt_q - ICW'(1);
      default: inCnt_d = inCnt_q;
    endcase
    case ({capture, outPop})
      2'b10:   outCnt_d = outCnt_q + OCW'(1);
      2'b01:   outCnt_d = outCnt_q - OCW'(1);
      default: outCnt_d = outCnt_q;
    endcase
    case ({launch, capture})
      2'b10:   inflight_d = inflight_q + OCW'(1);
      2'b01:   inflight_d = inflight_q - OCW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Control state; the tag shift register mirrors the core pipeline so that
  // its tail marks the exact cycle in which core_result is meaningful.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readyEn_q  <= 1'b0;
      inWr_q     <= '0;
      inRd_q     <= '0;
      inCnt_q    <= '0;
      outWr_q    <= '0;
      outRd_q    <= '0;
      outCnt_q   <= '0;
      inflight_q <= '0;
      coreA_q    <= '0;
      coreB_q    <= '0;
      coreVld_q  <= 1'b0;
      coreErr_q  <= 1'b0;
      srVld_q    <= '0;
      srErr_q    <= '0;
    end else begin
      readyEn_q  <= 1'b1;
      inWr_q     <= inWr_d;
      inRd_q     <= inRd_d;
      inCnt_q    <= inCnt_d;
      outWr_q    <= outWr_d;
      outRd_q    <= outRd_d;
      outCnt_q   <= outCnt_d;
      inflight_q <= inflight_d;
      coreA_q    <= coreA_d;
      coreB_q    <= coreB_d;
      coreVld_q  <= launch;
      coreErr_q  <= coreErr_d;
      srVld_q[0] <= coreVld_q;
      srErr_q[0] <= coreErr_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        srVld_q[i] <= srVld_q[i-1];
        srErr_q[i] <= srErr_q[i-1];
      end
    end
  end

  // FIFO storage needs no reset: reads are gated by the cleared counters.
  always_ff @(posedge clk) begin
    if (inPush) begin
      inMem_q[inWr_q] <= inEntry;
    end
    if (capture) begin
      outMem_q[outWr_q] <= {srErr_q[PIPE_LAT-1], core_result};
    end
  end

endmodule

// File: tb/tb_subinvmult_stream_ctrl.sv
module tb_subinvmult_stream_ctrl;

  localparam int DW   = 18;
  localparam int MOD  = 177147;
  localparam int PL   = 8;
  localparam int IND  = 4;
  localparam int OUTD = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] core_a;
  logic [DW-1:0] core_b;
  logic          core_vld;
  logic [DW-1:0] core_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  subinvmult_stream_ctrl #(
    .DATA_WIDTH(DW), .MODULUS(MOD), .PIPE_LAT(PL), .IN_DEPTH(IND), .OUT_DEPTH(OUTD)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_vld(core_vld), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  typedef struct {
    int a;
    int b;
    bit expErr;
    int expCoreA;
    int expCoreB;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;

  int expData [$];
  bit expErr [$];
  int expCA [$];
  int expCB [$];

  int          cyc = 0;
  int          launchCnt = 0;
  int          popCnt = 0;
  int          runLen = 0;
  int          validSeen = 0;
  bit          accFlag = 0;
  bit          holdPrev = 0;
  logic [DW:0] holdVal = '0;
  bit          readyMode = 0;

  logic [DW-1:0] corePipe [PL];

  // Behavioural stand-in for the arithmetic core and for the expected result.
  function automatic int refF(input int a, input int b);
    int d;
    d = (a - b + MOD) % MOD;
    return (d * 5 + 1) % MOD;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External core: fixed PIPE_LAT delay from operand cycle to result cycle.
  always @(posedge clk) begin
    corePipe[0] <= DW'(refF(int'(core_a), int'(core_b)));
    for (int i = 1; i < PL; i++) corePipe[i] <= corePipe[i-1];
  end
  assign core_result = corePipe[PL-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted pair is turned into an expected launch and an
  // expected result; launches and results must follow acceptance order.
  task automatic monitorLoop();
    bit bad;
    int ea, eb;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        accFlag  = 0;
        holdPrev = 0;
        runLen   = 0;
        expData.delete();
        expErr.delete();
        expCA.delete();
        expCB.delete();
      end else begin
        accFlag = in_valid && in_ready;
        if (accFlag) begin
          bad = (int'(in_a) >= MOD) || (int'(in_b) >= MOD);
          ea  = bad ? 0 : int'(in_a);
          eb  = bad ? 0 : int'(in_b);
          expCA.push_back(ea);
          expCB.push_back(eb);
          expErr.push_back(bad);
          expData.push_back(refF(ea, eb));
        end
        if (core_vld) begin
          launchCnt++;
          if (expCA.size() == 0) begin
            checkOutput("launch with no pending pair", 0, 1);
          end else begin
            checkOutput("core_a operand", core_a, expCA.pop_front());
            checkOutput("core_b operand", core_b, expCB.pop_front());
          end
        end
        if (out_valid) validSeen++;
        if (holdPrev) begin
          checkOutput("held out_valid", out_valid, 1);
          checkOutput("held out_err/out_data", {out_err, out_data}, holdVal);
        end
        if (out_valid && out_ready) begin
          popCnt++;
          runLen++;
          if (expData.size() == 0) begin
            checkOutput("result with no pending pair", 0, 1);
          end else begin
            checkOutput("out_data order", out_data, expData.pop_front());
            checkOutput("out_err order", out_err, expErr.pop_front());
          end
        end else begin
          runLen = 0;
        end
        holdPrev = out_valid && !out_ready;
        holdVal  = {out_err, out_data};
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (readyMode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic genPair(output logic [DW-1:0] a, output logic [DW-1:0] b);
    a = ($urandom_range(0, 7) == 0) ? DW'(MOD + $urandom_range(0, 1000)) : DW'($urandom_range(0, MOD - 1));
    b = ($urandom_range(0, 7) == 0) ? DW'(MOD + $urandom_range(0, 1000)) : DW'($urandom_range(0, MOD - 1));
  endtask

  // Offers random pairs back to back; called just after a rising edge.
  task automatic applyStimulus(input int n, input int budget, input bit strict,
                               output int sent, output int used);
    logic [DW-1:0] a, b;
    sent = 0;
    used = 0;
    genPair(a, b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (sent < n && used < budget) begin
      stepCycle();
      used++;
      if (accFlag) begin
        sent++;
        if (sent < n) begin
          genPair(a, b);
          in_a = a;
          in_b = b;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    if (strict) checkOutput("stream pairs accepted", sent, n);
  endtask

  task automatic waitDrain(input int budget);
    int c = 0;
    while ((expData.size() != 0 || expCA.size() != 0) && c < budget) begin
      stepCycle();
      c++;
    end
    checkOutput("drain completed, pending results", expData.size(), 0);
  endtask

  initial begin
    int sent, used, firstK, popBase, launchBase, validBase;
    int gotA, gotB, gotData;
    bit gotErr, seenLaunch, seenOut;
    vecs[0] = '{5, 2, 1'b0, 5, 2};
    vecs[1] = '{177147, 3, 1'b1, 0, 0};
    vecs[2] = '{7, 9, 1'b0, 7, 9};
    vecs[3] = '{177146, 177146, 1'b0, 177146, 177146};
    vecs[4] = '{0, 177147, 1'b1, 0, 0};
    vecs[5] = '{262143, 262143, 1'b1, 0, 0};
    vecs[6] = '{0, 0, 1'b0, 0, 0};
    vecs[7] = '{1, 177146, 1'b0, 1, 177146};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    fork
      monitorLoop();
    join_none

    #2;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset core_vld", core_vld, 0);
    checkOutput("reset core_a", core_a, 0);
    checkOutput("reset core_b", core_b, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_err", out_err, 0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready after reset release", in_ready, 1);

    // Single pair latency: accepted at an edge, visible 11 cycles later.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_a = DW'(5);
    in_b = DW'(2);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    firstK = -1;
    gotData = 0;
    gotErr = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid && firstK < 0) begin
        firstK  = k;
        gotData = int'(out_data);
        gotErr  = out_err;
      end
    end
    checkOutput("latency to out_valid", firstK, 11);
    checkOutput("single pair out_data", gotData, refF(5, 2));
    checkOutput("single pair out_err", gotErr, 0);
    @(posedge clk);
    #1;

    // Directed vectors, one pair at a time, including range boundaries.
    for (int i = 0; i < 8; i++) begin
      in_a = DW'(vecs[i].a);
      in_b = DW'(vecs[i].b);
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
        stepCycle();
        if (accFlag) break;
      end
      in_valid = 1'b0;
      seenLaunch = 0;
      seenOut = 0;
      gotA = -1;
      gotB = -1;
      gotData = -1;
      gotErr = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (core_vld && !seenLaunch) begin
          seenLaunch = 1;
          gotA = int'(core_a);
          gotB = int'(core_b);
        end
        if (out_valid) begin
          seenOut = 1;
          gotData = int'(out_data);
          gotErr = out_err;
          break;
        end
      end
      checkOutput($sformatf("vec%0d launched", i), seenLaunch, 1);
      checkOutput($sformatf("vec%0d core_a", i), gotA, vecs[i].expCoreA);
      checkOutput($sformatf("vec%0d core_b", i), gotB, vecs[i].expCoreB);
      checkOutput($sformatf("vec%0d result seen", i), seenOut, 1);
      checkOutput($sformatf("vec%0d out_err", i), gotErr, vecs[i].expErr);
      checkOutput($sformatf("vec%0d out_data", i), gotData, refF(vecs[i].expCoreA, vecs[i].expCoreB));
      @(posedge clk);
      #1;
    end

    // Output stalled: credit caps launches, input FIFO fills, then drain.
    out_ready = 1'b0;
    launchBase = launchCnt;
    popBase = popCnt;
    applyStimulus(30, 40, 1'b0, sent, used);
    @(negedge clk);
    checkOutput("stalled launches", launchCnt - launchBase, OUTD);
    checkOutput("stalled accepted pairs", sent, OUTD + IND);
    checkOutput("stalled in_ready", in_ready, 0);
    checkOutput("stalled out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(10, 200, 1'b1, sent, used);
    waitDrain(200);
    checkOutput("stall phase total results", popCnt - popBase, 30);

    // Back-to-back stream: one acceptance and one result per cycle.
    popBase = popCnt;
    applyStimulus(100, 150, 1'b1, sent, used);
    checkOutput("stream acceptance cycles", used, 100);
    waitDrain(100);
    checkOutput("stream results", popCnt - popBase, 100);
    checkOutput("stream consecutive results", runLen, 100);

    // Reset with results queued and pairs in flight.
    out_ready = 1'b0;
    applyStimulus(3, 20, 1'b1, sent, used);
    repeat (12) stepCycle();
    applyStimulus(5, 20, 1'b1, sent, used);
    repeat (3) stepCycle();
    checkOutput("pre-reset out_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid reset out_valid", out_valid, 0);
    checkOutput("mid reset in_ready", in_ready, 0);
    checkOutput("mid reset core_vld", core_vld, 0);
    checkOutput("mid reset out_data", out_data, 0);
    checkOutput("mid reset out_err", out_err, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    validBase = validSeen;
    launchBase = launchCnt;
    @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready after mid reset", in_ready, 1);
    @(posedge clk);
    #1;
    repeat (2 * PL) stepCycle();
    checkOutput("stale results after reset", validSeen - validBase, 0);
    checkOutput("stale launches after reset", launchCnt - launchBase, 0);

    // Random backpressure against the scoreboard.
    readyMode = 1'b1;
    popBase = popCnt;
    applyStimulus(200, 2000, 1'b1, sent, used);
    waitDrain(2000);
    checkOutput("random phase results", popCnt - popBase, 200);
    readyMode = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
